// File: rtl/window_3x3_gen_if.sv
// Pixel-stream in / 3x3-window-out bundle for window_3x3_gen.
// The master drives the raster pixel stream and observes the windows.
// The slave (the generator) consumes pixels and produces windows.
interface window_3x3_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    pix_valid;
  logic                    pix_sof;
  logic [DATA_WIDTH-1:0]   pix_data;
  logic                    win_valid;
  logic [9*DATA_WIDTH-1:0] win_data;
  logic                    win_eof;

  modport master (
    output pix_valid, pix_sof, pix_data,
    input  win_valid, win_data, win_eof
  );

  modport slave (
    input  pix_valid, pix_sof, pix_data,
    output win_valid, win_data, win_eof
  );
endinterface

// File: rtl/window_3x3_gen.sv
// Sliding 3x3 window generator over a raster pixel stream, two line memories.
// Latency: pixel accepted at edge k -> its window valid after edge k+1 (one cycle).
// No backpressure: every pix_valid cycle is consumed; border positions emit nothing.
module window_3x3_gen #(
  parameter int DATA_WIDTH   = 8,
  parameter int LINE_WIDTH   = 1920,
  parameter int FRAME_HEIGHT = 1080
) (
  input logic             clk,
  input logic             rst_n,
  window_3x3_gen_if.slave bus
);

  localparam int COL_W = $clog2(LINE_WIDTH);
  localparam int ROW_W = $clog2(FRAME_HEIGHT);
  localparam int WIN_W = 9 * DATA_WIDTH;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FRAME_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  // Raster position of the next pixel
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  // Position of the pixel on the bus this cycle (sof forces (0,0))
  logic [COL_W-1:0] col_cur;
  logic [ROW_W-1:0] row_cur;
  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row_nxt;

  // Line memories: lb1 holds line row-1, lb2 holds line row-2, both indexed by column
  logic [DATA_WIDTH-1:0] lb1 [LINE_WIDTH];
  logic [DATA_WIDTH-1:0] lb2 [LINE_WIDTH];

  // Stage 1 registers
  logic [DATA_WIDTH-1:0] lb1_rd;
  logic [DATA_WIDTH-1:0] lb2_rd;
  logic [DATA_WIDTH-1:0] s1_pix;
  logic                  s1_valid;
  logic                  s1_emit;
  logic                  s1_eof;

  // Stage 2: the tap array itself plus the output strobes
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_shift;
  logic             win_valid_q;
  logic             win_eof_q;

  // Current position (sof realigns) and the position that follows it
  always_comb begin
    col_cur = bus.pix_sof ? '0 : col;
    row_cur = bus.pix_sof ? '0 : row;
    col_nxt = col_cur + COL_W'(1);
    row_nxt = row_cur;
    if (col_cur == LAST_COL) begin
      col_nxt = '0;
      row_nxt = (row_cur == LAST_ROW) ? '0 : row_cur + ROW_W'(1);
    end
  end

  // Raster counters advance once per accepted pixel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (bus.pix_valid) begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  // Read-first line memories: old lb1 entry cascades into lb2; contents are never reset
  always_ff @(posedge clk) begin
    if (bus.pix_valid) begin
      lb1_rd       <= lb1[col_cur];
      lb2_rd       <= lb2[col_cur];
      lb1[col_cur] <= bus.pix_data;
      lb2[col_cur] <= lb1[col_cur];
    end
  end

  // Stage 1: capture the pixel and decide whether its window is complete
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_emit  <= 1'b0;
      s1_eof   <= 1'b0;
    end else begin
      s1_valid <= bus.pix_valid;
      if (bus.pix_valid) begin
        s1_pix  <= bus.pix_data;
        s1_emit <= (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);
        s1_eof  <= (row_cur == LAST_ROW) && (col_cur == LAST_COL);
      end
    end
  end

  // Tap array shifted one column left with the fresh column on the right
  always_comb begin
    win_shift = win_q;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 2; j++) begin
        win_shift[(3*i+j)*DATA_WIDTH +: DATA_WIDTH] = win_q[(3*i+j+1)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    win_shift[2*DATA_WIDTH +: DATA_WIDTH] = lb2_rd;
    win_shift[5*DATA_WIDTH +: DATA_WIDTH] = lb1_rd;
    win_shift[8*DATA_WIDTH +: DATA_WIDTH] = s1_pix;
  end

  // Stage 2: update taps on every stage-1 pixel, pulse valid only for full windows
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_eof_q   <= 1'b0;
    end else if (s1_valid) begin
      win_q       <= win_shift;
      win_valid_q <= s1_emit;
      win_eof_q   <= s1_emit && s1_eof;
    end else begin
      win_valid_q <= 1'b0;
      win_eof_q   <= 1'b0;
    end
  end

  assign bus.win_data  = win_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_eof   = win_eof_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on an 8x6 frame with ramp pixel data.
// Windows are compared against a frame-image reference, including arrival edge.
// Hand-computed first/last windows and per-frame window counts are checked too.
module tb_window_3x3_gen;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int FH = 6;
  localparam int WW = 9 * DW;

  typedef struct packed {
    logic [WW-1:0] dat;
    logic          eof;
    int unsigned   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  window_3x3_gen_if #(.DATA_WIDTH(DW)) bus ();

  window_3x3_gen #(
    .DATA_WIDTH  (DW),
    .LINE_WIDTH  (LW),
    .FRAME_HEIGHT(FH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // Reference frame image and raster position of the bench model
  logic [DW-1:0] img [FH][LW];
  int mr = 0;
  int mc = 0;
  exp_t exp_q[$];

  // Observed window log
  int unsigned    win_total = 0;
  int unsigned    eof_total = 0;
  logic [WW-1:0]  win_log [512];

  // Window checker, sampling on the falling edge
  always @(negedge clk) begin
    if (bus.win_valid === 1'b1) begin
      if (win_total < 512) win_log[win_total] = bus.win_data;
      win_total++;
      if (bus.win_eof === 1'b1) eof_total++;
      if (exp_q.size() == 0) begin
        check("spurious_win", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("win_data", bus.win_data, e.dat);
        check("win_eof", WW'(bus.win_eof), WW'(e.eof));
        check("win_latency", WW'(edge_cnt), WW'(e.due));
      end
    end else if (bus.win_eof !== 1'b0) begin
      check("eof_without_valid", WW'(bus.win_eof), 0);
    end
  end

  task automatic idle();
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic sof);
    exp_t e;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc]   = d;
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    bus.pix_data  = d;
    @(posedge clk);
    #1;
    if (mr >= 2 && mc >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.dat[(3*i+j)*DW +: DW] = img[mr-2+i][mc-2+j];
      e.eof = (mr == FH - 1) && (mc == LW - 1);
      e.due = edge_cnt + 1;
      exp_q.push_back(e);
    end
    mc++;
    if (mc == LW) begin
      mc = 0;
      mr = (mr == FH - 1) ? 0 : mr + 1;
    end
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  // Send pixels of a ramp frame from (0,0) up to but excluding linear index n
  task automatic send_ramp(input int offset, input logic use_sof, input logic gaps, input int n);
    for (int k = 0; k < n; k++) begin
      if (gaps) while ($urandom_range(1, 0) == 1) idle();
      send(DW'(offset + 8 * (k / LW) + (k % LW)), use_sof && (k == 0));
    end
  endtask

  task automatic drain();
    repeat (4) idle();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, WW'(bus.win_valid), 0);
    check({tag, "_eof"}, WW'(bus.win_eof), 0);
    check({tag, "_data"}, bus.win_data, 0);
  endtask

  localparam logic [WW-1:0] FIRST_W0   = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
  localparam logic [WW-1:0] LAST_W0    = {8'd47, 8'd46, 8'd45, 8'd39, 8'd38, 8'd37, 8'd31, 8'd30, 8'd29};
  localparam logic [WW-1:0] FIRST_W100 = {8'd118, 8'd117, 8'd116, 8'd110, 8'd109, 8'd108, 8'd102, 8'd101, 8'd100};

  int unsigned base;
  int unsigned ebase;

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_data  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle();

    // Continuous ramp frame with sof
    base  = win_total;
    ebase = eof_total;
    send_ramp(0, 1'b1, 1'b0, LW * FH);
    drain();
    check("f1_count", WW'(win_total - base), 24);
    check("f1_first", win_log[base], FIRST_W0);
    check("f1_last", win_log[base+23], LAST_W0);
    check("f1_eof_count", WW'(eof_total - ebase), 1);

    // Next frame without sof wraps implicitly
    base = win_total;
    send_ramp(0, 1'b0, 1'b0, LW * FH);
    drain();
    check("f2_count", WW'(win_total - base), 24);
    check("f2_first", win_log[base], FIRST_W0);
    check("f2_last", win_log[base+23], LAST_W0);

    // Random valid gaps
    base = win_total;
    send_ramp(0, 1'b1, 1'b1, LW * FH);
    drain();
    check("gap_count", WW'(win_total - base), 24);
    check("gap_first", win_log[base], FIRST_W0);
    check("gap_last", win_log[base+23], LAST_W0);

    // sof injected at pixel (3,4): one pending window from (3,3), then a fresh frame
    base = win_total;
    send_ramp(0, 1'b1, 1'b0, 3 * LW + 4);
    send_ramp(0, 1'b1, 1'b0, LW * FH);
    drain();
    check("sof_mid_count", WW'(win_total - base), 8 + 24);
    check("sof_mid_first_new", win_log[base+8], FIRST_W0);

    // Reset one cycle mid-row 3, right after pixel (3,2) is accepted
    base = win_total;
    send_ramp(0, 1'b1, 1'b0, 3 * LW + 3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    mr = 0;
    mc = 0;
    check_outputs_zero("mid_reset");
    rst_n = 1'b1;
    send_ramp(0, 1'b0, 1'b0, LW * FH);
    drain();
    check("mid_reset_count", WW'(win_total - base), 6 + 24);
    check("mid_reset_first_new", win_log[base+6], FIRST_W0);

    // Back-to-back frames with different ramps
    base = win_total;
    send_ramp(0, 1'b1, 1'b0, LW * FH);
    send_ramp(100, 1'b1, 1'b0, LW * FH);
    drain();
    check("b2b_count", WW'(win_total - base), 48);
    check("b2b_first_second", win_log[base+24], FIRST_W100);

    check("exp_queue_empty", WW'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
